// File: rtl/rv32i_pkg.sv
// Shared types and constants for the RV32I load/store path:
// LSU FSM state encoding, fun3 size/sign codes and the misalignment rule.
package rv32i_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_e;

    localparam logic [2:0] LS_B  = 3'b000;
    localparam logic [2:0] LS_H  = 3'b001;
    localparam logic [2:0] LS_W  = 3'b010;
    localparam logic [2:0] LS_BU = 3'b100;
    localparam logic [2:0] LS_HU = 3'b101;

    // size_bits is fun3[1:0]: 00 byte, 01 half, anything else is a word access.
    function automatic logic is_misaligned(input logic [1:0] size_bits, input logic [1:0] off);
        return ((size_bits == 2'b01) && off[0]) ||
               (size_bits[1] && (off != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Combinational byte-lane logic: store data replication and byte mask,
// and load data alignment with sign/zero extension.
module lsu_byte_lane
    import rv32i_pkg::*;
(
    input  logic [2:0]  st_fun3_i,
    input  logic [1:0]  st_off_i,
    input  logic [31:0] st_data_i,
    input  logic [2:0]  ld_fun3_i,
    input  logic [1:0]  ld_off_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] st_wdata_o,
    output logic [3:0]  st_wmask_o,
    output logic [31:0] ld_data_o
);

    logic [31:0] shifted;

    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis would infer a latch.
    always_comb begin
        st_wdata_o = st_data_i;
        st_wmask_o = 4'b1111;
        case (st_fun3_i)
            LS_B: begin
                st_wdata_o = {4{st_data_i[7:0]}};
                st_wmask_o = 4'b0001 << st_off_i;
            end
            LS_H: begin
                st_wdata_o = {2{st_data_i[15:0]}};
                st_wmask_o = 4'b0011 << {st_off_i[1], 1'b0};
            end
            default: ;
        endcase
    end

    always_comb begin
        shifted   = rdata_i >> {ld_off_i, 3'b000};
        ld_data_o = rdata_i;
        case (ld_fun3_i)
            LS_B:    ld_data_o = {{24{shifted[7]}}, shifted[7:0]};
            LS_H:    ld_data_o = {{16{shifted[15]}}, shifted[15:0]};
            LS_BU:   ld_data_o = {24'd0, shifted[7:0]};
            LS_HU:   ld_data_o = {16'd0, shifted[15:0]};
            default: ld_data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// RV32I load/store unit: request/grant/response handshake to data memory.
// Optional macro LSU_MISALIGN_CHECK_EN rejects misaligned half/word accesses.
module lsu
    import rv32i_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              store_i,
    input  logic [2:0]        fun3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] store_data,
    output logic [DATA_W-1:0] load_data,
    output logic              valid,
    output logic              load_control,
    output logic              misaligned,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_wmask,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);

    lsu_state_e        state_q;
    logic [2:0]        fun3_q;
    logic [1:0]        off_q;
    logic [DATA_W-1:0] load_data_q;
    logic              valid_q;
    logic              load_control_q;
    logic              misaligned_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [3:0]        mem_wmask_q;

    logic [DATA_W-1:0] st_wdata;
    logic [3:0]        st_wmask;
    logic [DATA_W-1:0] ld_data;
    logic              access_bad;

`ifdef LSU_MISALIGN_CHECK_EN
    assign access_bad = is_misaligned(fun3[1:0], addr[1:0]);
`else
    assign access_bad = 1'b0;
`endif

    // Store lanes come from the live request; load lanes from the captured one.
    lsu_byte_lane u_lane (
        .st_fun3_i  (fun3),
        .st_off_i   (addr[1:0]),
        .st_data_i  (store_data),
        .ld_fun3_i  (fun3_q),
        .ld_off_i   (off_q),
        .rdata_i    (mem_rdata),
        .st_wdata_o (st_wdata),
        .st_wmask_o (st_wmask),
        .ld_data_o  (ld_data)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            fun3_q         <= 3'b000;
            off_q          <= 2'b00;
            load_data_q    <= '0;
            valid_q        <= 1'b0;
            load_control_q <= 1'b0;
            misaligned_q   <= 1'b0;
            mem_req_q      <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            mem_wmask_q    <= 4'b0000;
        end else begin
            load_control_q <= 1'b0;
            misaligned_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (load_i || store_i) begin
                        if (access_bad) begin
                            misaligned_q <= 1'b1;
                        end else begin
                            state_q     <= REQ;
                            mem_req_q   <= 1'b1;
                            valid_q     <= 1'b1;
                            mem_we_q    <= ~load_i;   // load wins a double strobe
                            mem_addr_q  <= {addr[ADDR_W-1:2], 2'b00};
                            mem_wdata_q <= st_wdata;
                            mem_wmask_q <= st_wmask;
                            fun3_q      <= fun3;
                            off_q       <= addr[1:0];
                        end
                    end
                end
                REQ: begin
                    if (mem_gnt) begin
                        mem_req_q <= 1'b0;
                        if (mem_we_q) begin
                            state_q <= IDLE;
                            valid_q <= 1'b0;
                        end else if (mem_rvalid) begin
                            state_q        <= DONE;
                            valid_q        <= 1'b0;
                            load_control_q <= 1'b1;
                            load_data_q    <= ld_data;
                        end else begin
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        state_q        <= DONE;
                        valid_q        <= 1'b0;
                        load_control_q <= 1'b1;
                        load_data_q    <= ld_data;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign load_data    = load_data_q;
    assign valid        = valid_q;
    assign load_control = load_control_q;
    assign misaligned   = misaligned_q;
    assign mem_req      = mem_req_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign mem_wmask    = mem_wmask_q;

endmodule

// File: tb/tb_lsu.sv
// Directed self-checking bench for lsu: stores, loads, stalls, reset abort
// and the LSU_MISALIGN_CHECK_EN behaviour of whichever build is compiled.
module tb_lsu;
    import rv32i_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_i, store_i;
    logic [2:0]  fun3;
    logic [31:0] addr, store_data;
    logic [31:0] load_data;
    logic        valid, load_control, misaligned;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    lsu #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .load_i       (load_i),
        .store_i      (store_i),
        .fun3         (fun3),
        .addr         (addr),
        .store_data   (store_data),
        .load_data    (load_data),
        .valid        (valid),
        .load_control (load_control),
        .misaligned   (misaligned),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_wmask    (mem_wmask),
        .mem_gnt      (mem_gnt),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata)
    );

    // Advance one clock; outputs are then sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        load_i = 0; store_i = 0; mem_gnt = 0; mem_rvalid = 0;
    endtask

    task automatic test_reset();
        rst = 1; idle_inputs(); fun3 = 3'b000; addr = '0; store_data = '0; mem_rdata = '0;
        step(); step();
        total++; if (dut.state_q !== IDLE) $display("FAIL reset_state: got %0d want %0d", dut.state_q, IDLE); else passed++;
        total++; if ({mem_req, mem_we, valid, load_control, misaligned} !== 5'b0)
            $display("FAIL reset_flags: got %b want 00000", {mem_req, mem_we, valid, load_control, misaligned}); else passed++;
        total++; if ({mem_addr, mem_wdata, load_data, mem_wmask} !== 100'd0)
            $display("FAIL reset_data: addr %h wdata %h ldata %h mask %b want all zero", mem_addr, mem_wdata, load_data, mem_wmask); else passed++;
        rst = 0;
        step();
    endtask

    task automatic test_store_byte();
        int vcnt = 0, lcnt = 0;
        store_i = 1; fun3 = LS_B; addr = 32'h1003; store_data = 32'h0000_00A5; mem_gnt = 1;
        step();
        store_i = 0;
        total++; if (mem_req !== 1'b1 || mem_we !== 1'b1) $display("FAIL sb_req_we: got %b%b want 11", mem_req, mem_we); else passed++;
        total++; if (mem_wmask !== 4'b1000) $display("FAIL sb_mask: got %b want 1000", mem_wmask); else passed++;
        total++; if (mem_wdata !== 32'hA5A5_A5A5) $display("FAIL sb_wdata: got %h want a5a5a5a5", mem_wdata); else passed++;
        total++; if (mem_addr !== 32'h1000) $display("FAIL sb_addr: got %h want 00001000", mem_addr); else passed++;
        for (int i = 0; i < 4; i++) begin
            vcnt += int'(valid); lcnt += int'(load_control);
            step();
        end
        mem_gnt = 0;
        total++; if (vcnt !== 1) $display("FAIL sb_valid_cycles: got %0d want 1", vcnt); else passed++;
        total++; if (lcnt !== 0) $display("FAIL sb_no_load_control: got %0d want 0", lcnt); else passed++;
        total++; if (mem_req !== 1'b0) $display("FAIL sb_req_drop: got %b want 0", mem_req); else passed++;
    endtask

    task automatic test_load_byte_wait();
        load_i = 1; fun3 = LS_B; addr = 32'h2001;
        step();
        load_i = 0; mem_gnt = 1;
        total++; if (mem_we !== 1'b0 || mem_addr !== 32'h2000) $display("FAIL lb_req: we %b addr %h want 0 00002000", mem_we, mem_addr); else passed++;
        step();
        mem_gnt = 0;
        for (int i = 0; i < 3; i++) begin
            total++; if (valid !== 1'b1 || load_control !== 1'b0)
                $display("FAIL lb_wait%0d: valid %b lc %b want 1 0", i, valid, load_control); else passed++;
            step();
        end
        total++; if (valid !== 1'b1) $display("FAIL lb_valid_last: got %b want 1", valid); else passed++;
        mem_rvalid = 1; mem_rdata = 32'h0000_8000;
        step();
        mem_rvalid = 0; mem_rdata = 32'hDEAD_BEEF;
        total++; if (load_control !== 1'b1 || valid !== 1'b0) $display("FAIL lb_done: lc %b valid %b want 1 0", load_control, valid); else passed++;
        total++; if (load_data !== 32'hFFFF_FF80) $display("FAIL lb_data: got %h want ffffff80", load_data); else passed++;
        step();
        total++; if (load_control !== 1'b0) $display("FAIL lb_lc_pulse: got %b want 0", load_control); else passed++;
        total++; if (load_data !== 32'hFFFF_FF80) $display("FAIL lb_data_hold: got %h want ffffff80", load_data); else passed++;
    endtask

    task automatic test_load_half();
        // Both strobes high: the load must win.
        load_i = 1; store_i = 1; fun3 = LS_HU; addr = 32'h2002;
        step();
        load_i = 0; store_i = 0;
        total++; if (mem_we !== 1'b0) $display("FAIL lhu_load_wins: we %b want 0", mem_we); else passed++;
        mem_gnt = 1;
        step();
        mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'hBEEF_0000;
        step();
        mem_rvalid = 0;
        total++; if (load_data !== 32'h0000_BEEF || load_control !== 1'b1)
            $display("FAIL lhu_data: got %h lc %b want 0000beef 1", load_data, load_control); else passed++;
        step();
        // LH, granted and answered in the same cycle.
        load_i = 1; fun3 = LS_H;
        step();
        load_i = 0; mem_gnt = 1; mem_rvalid = 1;
        step();
        mem_gnt = 0; mem_rvalid = 0;
        total++; if (load_data !== 32'hFFFF_BEEF || load_control !== 1'b1)
            $display("FAIL lh_data: got %h lc %b want ffffbeef 1", load_data, load_control); else passed++;
        step();
    endtask

    task automatic test_gnt_stall();
        load_i = 1; fun3 = LS_W; addr = 32'h4000;
        step();
        // Strobes outside IDLE must be ignored.
        load_i = 0; store_i = 1; addr = 32'h5557; fun3 = LS_B;
        for (int i = 0; i < 4; i++) begin
            step();
            total++; if (mem_req !== 1'b1 || mem_addr !== 32'h4000 || mem_wmask !== 4'b1111 || mem_we !== 1'b0)
                $display("FAIL stall%0d: req %b addr %h mask %b we %b want 1 00004000 1111 0", i, mem_req, mem_addr, mem_wmask, mem_we); else passed++;
        end
        store_i = 0; mem_gnt = 1; mem_rvalid = 1; mem_rdata = 32'h1234_5678;
        step();
        mem_gnt = 0; mem_rvalid = 0;
        total++; if (load_control !== 1'b1 || load_data !== 32'h1234_5678 || mem_req !== 1'b0)
            $display("FAIL stall_done: lc %b data %h req %b want 1 12345678 0", load_control, load_data, mem_req); else passed++;
        step();
        total++; if (dut.state_q !== IDLE) $display("FAIL stall_idle: got %0d want %0d", dut.state_q, IDLE); else passed++;
    endtask

    task automatic test_reset_mid();
        int lcnt = 0;
        load_i = 1; fun3 = LS_W; addr = 32'h6000;
        step();
        load_i = 0; mem_gnt = 1;
        step();
        mem_gnt = 0;
        total++; if (dut.state_q !== WAIT) $display("FAIL rstmid_wait: got %0d want %0d", dut.state_q, WAIT); else passed++;
        rst = 1;
        step();
        rst = 0;
        total++; if (dut.state_q !== IDLE || mem_req !== 1'b0 || valid !== 1'b0)
            $display("FAIL rstmid_idle: state %0d req %b valid %b want %0d 0 0", dut.state_q, mem_req, valid, IDLE); else passed++;
        mem_rvalid = 1; mem_rdata = 32'hCAFE_F00D;
        for (int i = 0; i < 3; i++) begin
            step();
            lcnt += int'(load_control);
            mem_rvalid = 0;
        end
        total++; if (lcnt !== 0 || load_data !== 32'h0)
            $display("FAIL rstmid_late_rvalid: lc %0d data %h want 0 00000000", lcnt, load_data); else passed++;
    endtask

    task automatic test_misalign();
        load_i = 1; fun3 = LS_W; addr = 32'h3002;
        step();
        load_i = 0;
`ifdef LSU_MISALIGN_CHECK_EN
        total++; if (misaligned !== 1'b1 || mem_req !== 1'b0)
            $display("FAIL mis_pulse: mis %b req %b want 1 0", misaligned, mem_req); else passed++;
        step();
        total++; if (misaligned !== 1'b0 || mem_req !== 1'b0 || dut.state_q !== IDLE)
            $display("FAIL mis_end: mis %b req %b state %0d want 0 0 %0d", misaligned, mem_req, dut.state_q, IDLE); else passed++;
        step();
        total++; if (load_control !== 1'b0) $display("FAIL mis_no_lc: got %b want 0", load_control); else passed++;
`else
        total++; if (mem_req !== 1'b1 || mem_addr !== 32'h3000 || mem_wmask !== 4'b1111 || misaligned !== 1'b0)
            $display("FAIL nomis_req: req %b addr %h mask %b mis %b want 1 00003000 1111 0", mem_req, mem_addr, mem_wmask, misaligned); else passed++;
        mem_gnt = 1; mem_rvalid = 1; mem_rdata = 32'h0BAD_F00D;
        step();
        mem_gnt = 0; mem_rvalid = 0;
        total++; if (load_control !== 1'b1 || load_data !== 32'h0BAD_F00D)
            $display("FAIL nomis_done: lc %b data %h want 1 0badf00d", load_control, load_data); else passed++;
        step();
`endif
    endtask

    initial begin
        test_reset();
        test_store_byte();
        test_load_byte_wait();
        test_load_half();
        test_gnt_stall();
        test_reset_mid();
        test_misalign();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
